fsbus_flash_arbiter: RTL

FSBUS_FLASH_ARBITER -- requirements
Module: fsbus_flash_arbiter

---
 rtl/fsbus_flash_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fsbus_flash_arbiter.sv
// Round-robin two-requester arbiter for an asynchronous NOR flash on the
// shared FS bus; the SSRAM sharing the bus is parked deselected.
module fsbus_flash_arbiter #(
  parameter int T_SETUP    = 2,
  parameter int T_ACCESS   = 6,
  parameter int T_HOLD     = 1,
  parameter int RST_CYCLES = 16
) (
  input  logic        clkin_50,
  input  logic        cpu_resetn,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [24:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [24:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic [24:0] fsa,
  output logic [31:0] fsd_o,
  output logic        fsd_oe,
  input  logic [31:0] fsd_i,
  output logic        flash_cen,
  output logic        flash_oen,
  output logic        flash_wen,
  output logic        flash_resetn,
  input  logic        flash_rdybsyn,
  output logic        sram_csn,
  output logic        sram_oen,
  output logic        sram_wen,
  output logic        sram_advn,
  output logic [3:0]  sram_ben,
  output logic        busy
);

  localparam int M1   = (T_SETUP > T_ACCESS) ? T_SETUP : T_ACCESS;
  localparam int M2   = (T_HOLD > RST_CYCLES) ? T_HOLD : RST_CYCLES;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_RST,
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_TURN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sync;
  logic          w_rdy_s;
  logic          r_gnt_b;
  logic          w_gnt_b;
  logic          w_grant;
  logic          r_we;
  logic [24:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_a_rdata;
  logic [31:0]   r_b_rdata;
  logic          w_xfer;
  logic          w_turn;
  logic          w_capture;

  assign w_rdy_s = r_sync[1];

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_gnt_b = r_gnt_b;
    unique case (r_state)
      S_RST:
        if (r_cnt == CW'(RST_CYCLES - 1)) w_next = S_IDLE;
      S_IDLE:
        if (w_rdy_s && (a_req || b_req)) begin
          w_grant = 1'b1;
          // r_gnt_b doubles as last-grant: B wins only if A idle or A went last
          w_gnt_b = b_req && (!a_req || !r_gnt_b);
          w_next  = S_SETUP;
        end
      S_SETUP:
        if (r_cnt == CW'(T_SETUP - 1)) w_next = S_ACCESS;
      S_ACCESS:
        if (r_cnt == CW'(T_ACCESS - 1)) w_next = S_HOLD;
      S_HOLD:
        if (r_cnt == CW'(T_HOLD - 1)) w_next = S_TURN;
      S_TURN:
        w_next = S_IDLE;
      default:
        w_next = S_RST;
    endcase
  end

  assign w_capture = (r_state == S_ACCESS) && (w_next == S_HOLD);

  always_ff @(posedge clkin_50) begin
    if (!cpu_resetn) begin
      r_state   <= S_RST;
      r_cnt     <= '0;
      r_sync    <= '0;
      r_gnt_b   <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[0], flash_rdybsyn};
      if (w_next != r_state || r_state == S_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_grant) begin
        r_gnt_b <= w_gnt_b;
        r_we    <= w_gnt_b ? b_we : a_we;
        r_addr  <= w_gnt_b ? b_addr : a_addr;
        r_wdata <= w_gnt_b ? b_wdata : a_wdata;
      end
      if (w_capture && r_gnt_b) r_b_rdata <= fsd_i;
      if (w_capture && !r_gnt_b) r_a_rdata <= fsd_i;
    end
  end

  assign w_xfer = (r_state == S_SETUP) ||
                  (r_state == S_ACCESS) ||
                  (r_state == S_HOLD);
  assign w_turn = (r_state == S_TURN);

  assign fsa          = r_addr;
  assign fsd_o        = r_wdata;
  assign fsd_oe       = w_xfer && r_we;
  assign flash_cen    = !w_xfer;
  assign flash_oen    = !((r_state == S_ACCESS) && !r_we);
  assign flash_wen    = !((r_state == S_ACCESS) && r_we);
  assign flash_resetn = (r_state != S_RST);
  assign busy         = w_xfer || w_turn;
  assign a_ack        = w_turn && !r_gnt_b;
  assign b_ack        = w_turn && r_gnt_b;
  assign a_rdata      = r_a_rdata;
  assign b_rdata      = r_b_rdata;

  assign sram_csn  = 1'b1;
  assign sram_oen  = 1'b1;
  assign sram_wen  = 1'b1;
  assign sram_advn = 1'b1;
  assign sram_ben  = 4'hF;

endmodule
